// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and helpers for the bit-serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction
endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract over WIDTH cycles using one full adder
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cin_msb_q, cin_msb_d, cout_q, cout_d, ovf_q, ovf_d;
  logic fa_sum, fa_cout;
  fulladder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );
  // Next-state and datapath: load on start, shift one bit per RUN edge, publish on the last bit
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    if (state_q == IDLE && start) begin
      opa_d   = a;
      opb_d   = b ^ {WIDTH{sub}};
      acc_d   = '0;
      carry_d = sub;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      acc_d   = (acc_q >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      carry_d = fa_cout;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 2)) cin_msb_d = fa_cout;
      if (cnt_q == CW'(WIDTH - 1)) begin
        result_d = acc_d;
        cout_d   = fa_cout;
        ovf_d    = fa_cout ^ cin_msb_q;
        state_d  = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: table-driven and scoreboard checks of the serial adder/subtractor
module tb_serial_addsub_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout, overflow;
  logic [W-1:0] result;
  int errors = 0, checks = 0, ndone = 0;
  typedef struct {logic [W-1:0] r; logic c; logic v;} exp_t;
  typedef struct {logic s; logic [W-1:0] x; logic [W-1:0] y; exp_t e;} vec_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] yy;
    logic [W:0] t;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.r = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == yy[W-1]) && (e.r[W-1] != x[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_result", 32'(result), 32'(mon_e.r));
        chk("sb_cout", 32'(cout), 32'(mon_e.c));
        chk("sb_overflow", 32'(overflow), 32'(mon_e.v));
      end
    end
  end

  task automatic wait_done(input int pre, output int lat, output int bc);
    lat = pre;
    bc = pre;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done after %0d cycles expected %0d", lat, W + 1);
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e, input string name);
    int lat, bc;
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; sub = ~s; a = ~x; b = ~y;
    wait_done(0, lat, bc);
    chk({name, "_latency"}, 32'(lat), W + 1);
    chk({name, "_busy_cycles"}, 32'(bc), W + 1);
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 0);
    chk({name, "_idle_done"}, 32'(done), 0);
  endtask

  initial begin
    int lat, bc, nd0;
    logic s;
    logic [W-1:0] x, y;
    exp_t e;
    tbl[0] = '{1'b0, 8'd100, 8'd55,  '{8'h9B, 1'b0, 1'b1}};
    tbl[1] = '{1'b0, 8'd200, 8'd100, '{8'h2C, 1'b1, 1'b0}};
    tbl[2] = '{1'b1, 8'd5,   8'd9,   '{8'hFC, 1'b0, 1'b0}};
    tbl[3] = '{1'b0, 8'hFF,  8'hFF,  '{8'hFE, 1'b1, 1'b0}};
    tbl[4] = '{1'b0, 8'h7F,  8'h01,  '{8'h80, 1'b0, 1'b1}};
    tbl[5] = '{1'b1, 8'h00,  8'h00,  '{8'h00, 1'b1, 1'b0}};
    tbl[6] = '{1'b0, 8'h00,  8'h00,  '{8'h00, 1'b0, 1'b0}};
    tbl[7] = '{1'b1, 8'h80,  8'h01,  '{8'h7F, 1'b1, 1'b1}};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    foreach (tbl[i]) run_op(tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].e, $sformatf("vec%0d", i));
    nd0 = ndone;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'd100; b = 8'd55;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(ndone - nd0), 0);
    run_op(1'b0, 8'd3, 8'd4, '{8'd7, 1'b0, 1'b0}, "after_abort");
    nd0 = ndone;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'hFF; b = 8'h01;
    sb.push_back('{8'h00, 1'b1, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk);
    #1 start = 1'b0; a = 8'h5A; b = 8'hA5;
    wait_done(3, lat, bc);
    chk("busy_start_latency", 32'(lat), W + 1);
    repeat (12) @(negedge clk);
    chk("busy_start_single_done", 32'(ndone - nd0), 1);
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = 8'($urandom);
      e = model(s, x, y);
      run_op(s, x, y, e, $sformatf("rnd%0d", i));
    end
    repeat (5) @(negedge clk);
    chk("hold_result", 32'(result), 32'(e.r));
    chk("hold_cout", 32'(cout), 32'(e.c));
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
